// File: rtl/e_mdu.sv
// E-stage multiply/divide unit: HI/LO registers, MT/MF access and a down-counter
// sequenced MULT/MULTU/DIV/DIVU. Define MDU_FAST_EN to make every op complete at launch.
module e_mdu (
    input  logic        clk,
    input  logic        reset,
    input  logic        E_start,
    input  logic [3:0]  E_MDUop,
    input  logic [31:0] E_rs,
    input  logic [31:0] E_rt,
    output logic        E_busy,
    output logic [31:0] E_MDUout,
    output logic [31:0] HI,
    output logic [31:0] LO
);
    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MFHI  = 4'd5;
    localparam logic [3:0] OP_MFLO  = 4'd6;
    localparam logic [3:0] OP_MTHI  = 4'd7;
    localparam logic [3:0] OP_MTLO  = 4'd8;

    logic [31:0] r_hi;
    logic [31:0] r_lo;
    logic        w_busy;
    logic        w_accept;
    logic        w_launch;
    logic [64:0] w_res;

    // Result bundle {write_enable, hi, lo}; divide by zero clears write_enable.
    function automatic logic [64:0] f_calc(input logic [3:0] op, input logic [31:0] a,
                                           input logic [31:0] b);
        logic [63:0] prod;
        logic [31:0] q;
        logic [31:0] r;
        logic        wr;
        prod = 64'd0;
        q    = 32'd0;
        r    = 32'd0;
        wr   = 1'b0;
        case (op)
            OP_MULT: begin
                prod = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
                wr   = 1'b1;
            end
            OP_MULTU: begin
                prod = {32'd0, a} * {32'd0, b};
                wr   = 1'b1;
            end
            OP_DIV: begin
                if (b != 32'd0) begin
                    wr = 1'b1;
                    // Overflow case is pinned explicitly rather than left to the divider.
                    if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                        q = 32'h8000_0000;
                        r = 32'd0;
                    end else begin
                        q = $signed(a) / $signed(b);
                        r = $signed(a) % $signed(b);
                    end
                end
            end
            OP_DIVU: begin
                if (b != 32'd0) begin
                    wr = 1'b1;
                    q  = a / b;
                    r  = a % b;
                end
            end
            default: wr = 1'b0;
        endcase
        if (op == OP_DIV || op == OP_DIVU) prod = {r, q};
        return {wr, prod};
    endfunction

    assign w_accept = E_start && !w_busy;
    assign w_launch = w_accept && (E_MDUop >= OP_MULT) && (E_MDUop <= OP_DIVU);

`ifdef MDU_FAST_EN
    assign w_busy = 1'b0;
    assign w_res  = f_calc(E_MDUop, E_rs, E_rt);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_hi <= 32'd0;
            r_lo <= 32'd0;
        end else begin
            if (w_launch && w_res[64]) begin
                r_hi <= w_res[63:32];
                r_lo <= w_res[31:0];
            end
            if (w_accept && E_MDUop == OP_MTHI) r_hi <= E_rs;
            if (w_accept && E_MDUop == OP_MTLO) r_lo <= E_rs;
        end
    end
`else
    logic [3:0]  r_cnt;
    logic [3:0]  r_op;
    logic [31:0] r_a;
    logic [31:0] r_b;

    assign w_busy = (r_cnt != 4'd0);
    assign w_res  = f_calc(r_op, r_a, r_b);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_hi  <= 32'd0;
            r_lo  <= 32'd0;
            r_cnt <= 4'd0;
            r_op  <= 4'd0;
            r_a   <= 32'd0;
            r_b   <= 32'd0;
        end else begin
            if (w_busy) begin
                r_cnt <= r_cnt - 4'd1;
                // HI/LO only change on the edge the counter reaches zero.
                if (r_cnt == 4'd1 && w_res[64]) begin
                    r_hi <= w_res[63:32];
                    r_lo <= w_res[31:0];
                end
            end else if (w_launch) begin
                r_cnt <= (E_MDUop <= OP_MULTU) ? 4'd5 : 4'd10;
                r_op  <= E_MDUop;
                r_a   <= E_rs;
                r_b   <= E_rt;
            end
            if (w_accept && E_MDUop == OP_MTHI) r_hi <= E_rs;
            if (w_accept && E_MDUop == OP_MTLO) r_lo <= E_rs;
        end
    end
`endif

    always_comb begin
        E_MDUout = 32'd0;
        if (E_MDUop == OP_MFHI) E_MDUout = r_hi;
        else if (E_MDUop == OP_MFLO) E_MDUout = r_lo;
    end

    assign E_busy = w_busy;
    assign HI     = r_hi;
    assign LO     = r_lo;
endmodule
